// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
//
// Ports:
//   clk, resetn             clock (rising edge), asynchronous active-low reset
//   issue_valid             decoded instruction valid this cycle
//   div_mul_control[3:0]    one-hot op: bit0 div, bit1 divu, bit2 mult, bit3 multu
//   hi_lo_control[1:0]      bit0 mthi, bit1 mtlo (data taken from src1)
//   src1, src2              rs / rt operands
//   hi, lo                  architectural HI/LO registers
//   busy                    operation in progress (registered)
//   stall                   pipeline stall, equal to busy
//   done                    one-cycle pulse in the first idle cycle after an operation
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             issue_valid,
    input  logic [3:0]       div_mul_control,
    input  logic [1:0]       hi_lo_control,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q;
    // Shared working register: {product_hi, product_lo} for multiply,
    // {remainder, dividend/quotient} for divide.
    logic [2*WIDTH-1:0] acc_q;
    // Multiplicand (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q;
    logic               neg_q;      // negate product / quotient at the end
    logic               neg_r_q;    // negate remainder at the end
    logic               div0_q;     // divide by zero: quotient forced to all ones
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Issue decode
    logic             any_md, accept, mt_write, last;
    logic             op_div, op_signed, s1_neg, s2_neg;
    logic [WIDTH-1:0] mag1, mag2;

    assign any_md    = |div_mul_control;
    assign accept    = issue_valid && (state_q == IDLE) && any_md;
    assign mt_write  = issue_valid && (state_q == IDLE) && !any_md;
    assign last      = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

    // Priority div > divu > mult > multu falls out of this decode.
    assign op_div    = div_mul_control[0] | div_mul_control[1];
    assign op_signed = div_mul_control[0] |
                       (!div_mul_control[1] && div_mul_control[2]);
    assign s1_neg    = op_signed & src1[WIDTH-1];
    assign s2_neg    = op_signed & src2[WIDTH-1];
    assign mag1      = s1_neg ? -src1 : src1;
    assign mag2      = s2_neg ? -src2 : src2;

    // One multiply step: conditional add into the upper half, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring-divide step: shift the next dividend bit into the
    // remainder and subtract the divisor if it fits. The W-bit subtraction
    // is exact whenever it is used, because the result is below the divisor.
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_sub, div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ok    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    assign div_rem   = div_ok ? div_sub : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0] acc_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fin_hi, fin_lo;

    assign acc_next = is_div_q ? div_next : mul_next;
    assign prod_fix = neg_q ? -acc_next : acc_next;
    assign quo_fix  = div0_q ? {WIDTH{1'b1}} :
                      (neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0]);
    // With a zero divisor the remainder ends up as |src1|, so the dividend
    // sign fix-up reproduces src1 exactly.
    assign rem_fix  = neg_r_q ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    assign fin_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fin_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and architectural registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= last;
            if (accept) begin
                cnt_q    <= '0;
                acc_q    <= {{WIDTH{1'b0}}, (op_div ? mag1 : mag2)};
                opnd_q   <= op_div ? mag2 : mag1;
                is_div_q <= op_div;
                neg_q    <= s1_neg ^ s2_neg;
                neg_r_q  <= s1_neg;
                div0_q   <= op_div && (src2 == '0);
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= acc_next;
            end

            if (last) begin
                hi_q <= fin_hi;
                lo_q <= fin_lo;
            end else if (mt_write) begin
                if (hi_lo_control[0]) hi_q <= src1;
                if (hi_lo_control[1]) lo_q <= src1;
            end
        end
    end

    assign busy  = (state_q == RUN);
    assign stall = busy;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard testbench for mul_div_unit
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         issue_valid = 1'b0;
    logic [3:0]   dmc = '0;
    logic [1:0]   hlc = '0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic [W-1:0] hi, lo;
    logic         busy, stall, done;

    int total = 0;
    int bad = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .issue_valid     (issue_valid),
        .div_mul_control (dmc),
        .hi_lo_control   (hlc),
        .src1            (src1),
        .src2            (src2),
        .hi              (hi),
        .lo              (lo),
        .busy            (busy),
        .stall           (stall),
        .done            (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {HI, LO} from language arithmetic on 64-bit values.
    function automatic logic [63:0] model(input logic [3:0] d, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb_, q, r;
        logic [63:0] ua, ub;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        if (d[0]) begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb_;
            r = sa % sb_;
            return {32'(r), 32'(q)};
        end else if (d[1]) begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {32'(ua % ub), 32'(ua / ub)};
        end else if (d[2]) begin
            return 64'(sa * sb_);
        end else begin
            return ua * ub;
        end
    endfunction

    // Scoreboard consumer: every done pulse retires one expected result.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("hi", {32'b0, hi}, {32'b0, e[63:32]});
                check("lo", {32'b0, lo}, {32'b0, e[31:0]});
            end
        end
    end

    task automatic run_op(input logic [3:0] d, input logic [1:0] h, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at);
        int cycles;
        logic [31:0] hold_hi;
        cycles = 0;
        sb.push_back(model(d, a, b));
        @(negedge clk);
        issue_valid = 1'b1; dmc = d; hlc = h; src1 = a; src2 = b;
        @(negedge clk);
        issue_valid = 1'b0; dmc = '0; hlc = '0;
        hold_hi = hi;
        while (busy && cycles < 200) begin
            if (cycles == 0) check("stall_busy", {63'b0, stall}, 64'd1);
            if (inject_at != 0 && cycles == inject_at) begin
                issue_valid = 1'b1; hlc = 2'b01; dmc = 4'b0010;
                src1 = 32'hAAAA; src2 = 32'd1;
            end else begin
                issue_valid = 1'b0; hlc = '0; dmc = '0;
            end
            if (inject_at != 0 && cycles == inject_at + 2)
                check("hi_hold", {32'b0, hi}, {32'b0, hold_hi});
            cycles++;
            @(negedge clk);
        end
        issue_valid = 1'b0; dmc = '0; hlc = '0;
        check("busy_cycles", 64'(cycles), 64'd32);
        check("done", {63'b0, done}, 64'd1);
        check("stall_idle", {63'b0, stall}, 64'd0);
        @(negedge clk);
        check("done_pulse", {63'b0, done}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_ctl", {61'b0, busy, done, stall}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_hilo", {hi, lo}, 64'd0);
        check("idle_ctl", {61'b0, busy, done, stall}, 64'd0);

        // Multiply
        run_op(4'b0100, 2'b00, 32'hFFFF_FFFF, 32'd2, 0);
        check("mult_direct", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(4'b1000, 2'b00, 32'hFFFF_FFFF, 32'd2, 0);
        check("multu_direct", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        // Divide, including overflow and zero divisor
        run_op(4'b0001, 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_direct", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'b0010, 2'b00, 32'd7, 32'd2, 0);
        run_op(4'b0001, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_direct", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(4'b0010, 2'b00, 32'd5, 32'd0, 0);
        check("divu0_direct", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        run_op(4'b0001, 2'b00, 32'hFFFF_FFFB, 32'd0, 0);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        issue_valid = 1'b1; hlc = 2'b01; src1 = 32'h1234;
        @(negedge clk);
        check("mthi", {32'b0, hi}, 64'h1234);
        check("mthi_busy", {63'b0, busy}, 64'd0);
        hlc = 2'b10; src1 = 32'h5678;
        @(negedge clk);
        issue_valid = 1'b0; hlc = '0;
        check("mtlo", {hi, lo}, {32'h1234, 32'h5678});
        check("mt_done", {62'b0, busy, done}, 64'd0);

        // Requests while busy are dropped
        run_op(4'b0100, 2'b00, 32'd3, 32'd4, 5);
        check("ignore_direct", {hi, lo}, 64'd12);

        // Asynchronous reset mid-operation
        @(negedge clk);
        issue_valid = 1'b1; dmc = 4'b0010; src1 = 32'd100; src2 = 32'd7;
        @(negedge clk);
        issue_valid = 1'b0; dmc = '0;
        repeat (9) @(negedge clk);
        check("mid_busy", {63'b0, busy}, 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_hilo", {hi, lo}, 64'd0);
        check("async_ctl", {61'b0, busy, done, stall}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(4'b1000, 2'b00, 32'd6, 32'd7, 0);

        // Random ops, multi-hot controls and mt bits alongside mul/div
        for (int i = 0; i < 8; i++) begin
            logic [3:0] d;
            logic [31:0] a, b;
            d = 4'($urandom_range(1, 15));
            a = $urandom;
            b = (i % 3 == 0) ? 32'd0 : ((i % 3 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op(d, 2'($urandom_range(0, 3)), a, b, 0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, directly downstream of the instruction decoder. It consumes the decoder's div_mul_control and hi_lo_control one-hot vectors plus the two register operands. It computes MULT/MULTU/DIV/DIVU in WIDTH cycles and handles MTHI/MTLO writes. HI/LO feed the write-back mux for MFHI/MFLO. While busy it asserts a stall to the pipeline.

Parameters:
WIDTH, 32, operand width; an operation takes WIDTH busy cycles (one bit per cycle).

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
issue_valid  input  1  decoded instruction is valid this cycle
div_mul_control  input  4  bit0 div, bit1 divu, bit2 mult, bit3 multu
hi_lo_control  input  2  bit0 mthi, bit1 mtlo
src1  input  WIDTH  rs value (dividend / multiplicand / MTHI/MTLO data)
src2  input  WIDTH  rt value (divisor / multiplier)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in progress (registered)
stall  output  1  combinational; equals busy
done  output  1  one-cycle pulse; new HI/LO visible this cycle

Behaviour:
- Reset: resetn low asynchronously clears hi, lo, busy, done, iteration counter and datapath registers. Reset mid-operation abandons the operation. HI/LO read 0 after reset.
- Accept: a rising edge with issue_valid=1, busy=0 and |div_mul_control starts an operation. Operands latch on that edge.
- Priority when more than one control bit is set: div > divu > mult > multu. Any mul/div op beats mthi/mtlo; a dropped mthi/mtlo is not written.
- FSM:
  - IDLE -> RUN on accept; counter=0.
  - RUN: one iteration per cycle; counter increments.
  - When counter=WIDTH-1, the edge writes HI/LO and returns to IDLE.
  - busy=1 exactly in RUN, i.e. WIDTH cycles.
  - done=1 in the first IDLE cycle after RUN, and only then.
- Latency: acceptance edge E0 -> HI/LO updated at edge E(WIDTH) -> done high in the following cycle.
- Multiply:
  - Shift-add on magnitudes over WIDTH iterations; product negated if signs differ (mult only).
  - LO = product[WIDTH-1:0], HI = product[2*WIDTH-1:WIDTH].
- Divide:
  - Restoring divide on magnitudes. Signed fix-up: quotient sign = sign(src1)^sign(src2); remainder sign = sign(src1).
  - LO = quotient, HI = remainder.
  - Overflow case div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): LO=all ones, HI=src1. No exception, still WIDTH cycles.
- MTHI/MTLO: with issue_valid=1, busy=0 and no mul/div bit, bit0 writes src1 to HI and bit1 writes src1 to LO on that edge. Both bits set writes both. Takes effect in 1 cycle; busy stays 0; done stays 0.
- While busy=1: all issue_valid requests (mul/div/mthi/mtlo) are ignored. The pipeline must hold them via stall and re-present them after busy falls. hi/lo keep their old values until the final edge.
- Back-to-back: a new op is acceptable on the edge that ends the done cycle (busy=0 then).
- No cancel input; in-flight ops always complete unless reset.

Test Plan:
- Reset: assert resetn=0 -> hi=lo=0, busy=done=stall=0; release, idle for 5 cycles -> values unchanged.
- mult src1=0xFFFFFFFF, src2=2 -> busy for exactly 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE with done=1 for 1 cycle. multu with same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div src1=0xFFFFFFF9 (-7), src2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 5/0 -> LO=0xFFFFFFFF, HI=5 after 32 cycles; div 0xFFFFFFFB/0 -> LO=0xFFFFFFFF, HI=0xFFFFFFFB.
- mthi 0x1234 then mtlo 0x5678 on consecutive cycles -> hi=0x1234 and lo=0x5678 one cycle each after issue, busy=0. Start mult 3*4, then issue mthi 0xAAAA and divu on busy cycle 5 -> both ignored; final HI=0, LO=12.
- Start divu 100/7, drive resetn=0 at busy cycle 10 -> busy, hi, lo clear immediately with no clock. Release and issue multu 6*7 -> LO=42, HI=0 after 32 cycles.
